// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types
// Description : Shared LC-3b pipeline types: redirect FSM state and the
//               grouped per-stage load/flush control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    typedef enum logic [0:0] {
        RUN           = 1'b0,
        REDIRECT_WAIT = 1'b1
    } lc3b_pipe_state;

    typedef struct packed {
        logic load_pc;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
    } lc3b_pipe_ctrl;

    localparam lc3b_pipe_ctrl c_ctrl_freeze = '0;
    localparam lc3b_pipe_ctrl c_ctrl_run    = '{load_pc: 1'b1, load_if_id: 1'b1,
                                                load_id_ex: 1'b1, load_ex_mem: 1'b1,
                                                load_mem_wb: 1'b1, flush_if_id: 1'b0,
                                                flush_id_ex: 1'b0, flush_ex_mem: 1'b0};

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; clear beats increment.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_control.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_control
// Description : LC-3b stall/flush controller with I-cache-safe branch redirect
//               FSM and saturating stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_control
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_load,
    input  logic             icache_read,
    input  logic             icache_resp,
    input  logic             dcache_req,
    input  logic             dcache_resp,
    input  logic             branch_taken,
    input  logic             clr_counters,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             latch_target,
    output logic             pc_sel_redirect,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    lc3b_pipe_state r_state;
    lc3b_pipe_state w_state_next;
    lc3b_pipe_ctrl  w_ctrl;
    logic           w_latch_target;
    logic           w_pc_sel_redirect;
    logic           w_branch_accept;
    logic           w_imem_busy;
    logic           w_dmem_busy;

    assign w_imem_busy = icache_read & ~icache_resp;
    assign w_dmem_busy = dcache_req & ~dcache_resp;

    always_comb begin
        w_ctrl            = c_ctrl_freeze;
        w_state_next      = r_state;
        w_latch_target    = 1'b0;
        w_pc_sel_redirect = 1'b0;
        w_branch_accept   = 1'b0;

        case (r_state)
            RUN: begin
                if (w_dmem_busy) begin
                    w_ctrl = c_ctrl_freeze;
                end else if (branch_taken && !w_imem_busy) begin
                    w_ctrl              = c_ctrl_run;
                    w_ctrl.flush_if_id  = 1'b1;
                    w_ctrl.flush_id_ex  = 1'b1;
                    w_ctrl.flush_ex_mem = 1'b1;
                    w_branch_accept     = 1'b1;
                end else if (branch_taken) begin
                    // Fetch in flight: park the target and hold PC until it lands.
                    w_ctrl              = c_ctrl_run;
                    w_ctrl.load_pc      = 1'b0;
                    w_ctrl.load_if_id   = 1'b0;
                    w_ctrl.flush_id_ex  = 1'b1;
                    w_ctrl.flush_ex_mem = 1'b1;
                    w_latch_target      = 1'b1;
                    w_branch_accept     = 1'b1;
                    w_state_next        = REDIRECT_WAIT;
                end else if (stall_load) begin
                    w_ctrl              = c_ctrl_run;
                    w_ctrl.load_pc      = 1'b0;
                    w_ctrl.load_if_id   = 1'b0;
                    w_ctrl.load_id_ex   = 1'b0;
                    w_ctrl.flush_ex_mem = 1'b1;
                end else if (w_imem_busy) begin
                    w_ctrl             = c_ctrl_run;
                    w_ctrl.load_pc     = 1'b0;
                    w_ctrl.load_if_id  = 1'b0;
                    w_ctrl.flush_id_ex = 1'b1;
                end else begin
                    w_ctrl = c_ctrl_run;
                end
            end

            REDIRECT_WAIT: begin
                w_ctrl             = c_ctrl_run;
                w_ctrl.flush_id_ex = 1'b1;
                if (icache_resp) begin
                    // The returning fetch is wrong-path; drop it into IF/ID as a bubble.
                    w_ctrl.flush_if_id = 1'b1;
                    w_pc_sel_redirect  = 1'b1;
                    w_state_next       = RUN;
                end else begin
                    w_ctrl.load_pc    = 1'b0;
                    w_ctrl.load_if_id = 1'b0;
                end
            end

            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign load_pc         = w_ctrl.load_pc;
    assign load_if_id      = w_ctrl.load_if_id;
    assign load_id_ex      = w_ctrl.load_id_ex;
    assign load_ex_mem     = w_ctrl.load_ex_mem;
    assign load_mem_wb     = w_ctrl.load_mem_wb;
    assign flush_if_id     = w_ctrl.flush_if_id;
    assign flush_id_ex     = w_ctrl.flush_id_ex;
    assign flush_ex_mem    = w_ctrl.flush_ex_mem;
    assign latch_target    = w_latch_target;
    assign pc_sel_redirect = w_pc_sel_redirect;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_counters),
        .inc   (~w_ctrl.load_pc),
        .count (stall_count)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_counters),
        .inc   (w_branch_accept),
        .count (flush_count)
    );

endmodule
`default_nettype wire

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Stall/flush controller sitting directly downstream of the hazard unit; consumes its stall_load plus I/D-cache handshakes and branch resolution.
- Drives load enables and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers of the LC-3b pipeline.
- Owns a two-state redirect FSM so a taken branch never changes PC under an outstanding I-cache read, and keeps saturating stall/flush performance counters.

Parameters:
CNT_W, 16, width of stall_count and flush_count

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
stall_load  in  1  load-use stall request from hazard unit
icache_read  in  1  IF stage has an I-cache read in flight
icache_resp  in  1  I-cache read complete this cycle
dcache_req  in  1  MEM stage instruction is reading or writing D-cache
dcache_resp  in  1  D-cache access complete this cycle
branch_taken  in  1  MEM-stage control transfer resolved taken
clr_counters  in  1  synchronous clear of perf counters
load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register load enables
flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  load a NOP (valid=0) instead of upstream data when the matching load_* is 1
latch_target  out  1  capture branch target into datapath redirect register
pc_sel_redirect  out  1  PC mux selects redirect register
stall_count  out  CNT_W  cycles with load_pc=0
flush_count  out  CNT_W  taken redirects

Behaviour:
- Definitions: imem_busy = icache_read & ~icache_resp; dmem_busy = dcache_req & ~dcache_resp.
- FSM states RUN, REDIRECT_WAIT (enum). Reset: state RUN, counters 0. All control outputs are combinational from state and inputs; no added latency.
- RUN, priority top-down:
  1. dmem_busy: all load_* = 0, all flush_* = 0 (full freeze); branch_taken and stall_load ignored.
  2. branch_taken & ~imem_busy: all load_* = 1; flush_if_id = flush_id_ex = flush_ex_mem = 1; pc_sel_redirect = 0; PC takes live target. Stay RUN.
  3. branch_taken & imem_busy: load_pc = load_if_id = 0; load_id_ex = load_ex_mem = load_mem_wb = 1; flush_id_ex = flush_ex_mem = 1; latch_target = 1; next state REDIRECT_WAIT.
  4. stall_load: load_pc = load_if_id = load_id_ex = 0; load_ex_mem = 1 with flush_ex_mem = 1; load_mem_wb = 1.
  5. imem_busy: load_pc = load_if_id = 0; load_id_ex = 1 with flush_id_ex = 1; load_ex_mem = load_mem_wb = 1.
  6. Otherwise: all load_* = 1, no flush.
- REDIRECT_WAIT:
  - Inputs branch_taken and stall_load are ignored; pipeline drains bubbles.
  - Each cycle: load_id_ex = load_ex_mem = load_mem_wb = 1; flush_id_ex = 1.
  - dcache_req is impossible here (EX/MEM holds a bubble).
  - While ~icache_resp: load_pc = load_if_id = 0.
  - On icache_resp: load_pc = 1, pc_sel_redirect = 1, load_if_id = 1, flush_if_id = 1 (wrong-path fetch discarded); next state RUN.
- latch_target and pc_sel_redirect are 0 everywhere not stated.
- Counters (sequential, synchronous to clk):
  - stall_count += 1 each cycle load_pc == 0.
  - flush_count += 1 on the cycle a taken branch is accepted (cases 2 and 3 only; not again on redirect completion).
  - Both saturate at all-ones.
  - clr_counters has priority over increment.
- Reset asserted mid-REDIRECT_WAIT: immediate return to RUN, counters 0, pending redirect dropped.

Decomposition:
- Shared package lc3b_types gains lc3b_pipe_state enum {RUN, REDIRECT_WAIT} and a packed lc3b_pipe_ctrl struct grouping load_*/flush_* bits.
- One sub-module sat_counter #(W) (clk, rst_n, clr, inc, count), instantiated twice.

Test Plan:
- Idle, no requests, 5 cycles -> all load_* = 1, no flush, stall_count = 0.
- dcache_req = 1 for 3 cycles, resp on 3rd; simultaneous stall_load = 1 and branch_taken = 1 -> cycles 1–2 all load_* = 0 with branch ignored; cycle 3 resp plus branch_taken takes case 2 with three flushes; stall_count = 2, flush_count = 1.
- stall_load = 1 one cycle, no cache activity -> load_pc/if_id/id_ex = 0, load_ex_mem = 1 with flush_ex_mem = 1; stall_count = 1.
- branch_taken with icache_read pending, icache_resp 4 cycles later -> latch_target = 1 cycle 0; REDIRECT_WAIT 3 cycles with flush_id_ex = 1; on resp load_pc = pc_sel_redirect = flush_if_id = 1; flush_count = 1, stall_count = 4.
- rst_n low during REDIRECT_WAIT -> state RUN, counters 0 asynchronously; after release with no inputs, all load_* = 1.
- CNT_W = 4, force 20 stall cycles; assert clr_counters concurrent with a stall -> stall_count sticks at 15, then reads 0 the cycle after clear.
